// File: rtl/enc_evt_fifo.sv
// enc_evt_fifo: turns the output of an 8-to-3 priority encoder into a queue of events.
// An event is a new code: valid rises, or the code changes while valid stays high.
// Each event is pushed into a first-word-fall-through FIFO of DEPTH entries.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   Y        in   [2:0] encoded index, meaningful only when valid=1
//   valid    in   encoder valid
//   rd_en    in   consumer pop request; ignored while the queue is empty
//   dout     out  [2:0] head-of-queue code, 3'b000 while empty
//   dout_vld out  queue non-empty
//   full     out  count == DEPTH
//   count    out  [CW-1:0] occupancy, 0..DEPTH
//   ovf      out  sticky flag, set when an event is dropped; cleared only by reset
//   drop_cnt out  [7:0] saturating count of dropped events
//                 (present only when ENC_EVT_DROP_CNT_EN is defined)
//
// Optional feature macro: ENC_EVT_DROP_CNT_EN

module enc_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    Y,
  input  logic          valid,
  input  logic          rd_en,
  output logic [2:0]    dout,
  output logic          dout_vld,
  output logic          full,
  output logic [CW-1:0] count,
`ifdef ENC_EVT_DROP_CNT_EN
  output logic [7:0]    drop_cnt,
`endif
  output logic          ovf
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic          r_prev_valid;
  logic [2:0]    r_prev_y;
  logic [2:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_evt;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [PW-1:0] w_wptr_nxt;
  logic [PW-1:0] w_rptr_nxt;

  // A code held steady produces exactly one event.
  assign w_evt   = valid && (!r_prev_valid || (Y != r_prev_y));
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = rd_en && !w_empty;
  // A simultaneous pop frees the slot, so a push into a full queue still lands.
  assign w_push  = w_evt && (!w_full || w_pop);
  assign w_drop  = w_evt && w_full && !w_pop;

  assign w_wptr_nxt = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_valid <= 1'b0;
      r_prev_y     <= 3'b000;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_prev_valid <= valid;
      r_prev_y     <= Y;
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wptr] <= Y;
  end

`ifdef ENC_EVT_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign dout     = w_empty ? 3'b000 : r_mem[r_rptr];
  assign dout_vld = !w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_enc_evt_fifo.sv
module tb_enc_evt_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [2:0]    y;
  logic          valid;
  logic          rd_en;
  logic [2:0]    dout;
  logic          dout_vld;
  logic          full;
  logic [CW-1:0] count;
  logic          ovf;
`ifdef ENC_EVT_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int n_vec;
  int n_err;

  enc_evt_fifo #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .Y       (y),
    .valid   (valid),
    .rd_en   (rd_en),
    .dout    (dout),
    .dout_vld(dout_vld),
    .full    (full),
    .count   (count),
`ifdef ENC_EVT_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    y     = 3'b000;
    rd_en = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (dout !== 3'b000) begin n_err++; $display("FAIL reset_dout got %b want 000", dout); end
    n_vec++;
    if (dout_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", dout_vld); end
    n_vec++;
    if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    n_vec++;
    if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
  endtask

  task automatic test_hold();
    do_reset();
    valid = 1'b1;
    y     = 3'd5;
    step();
    n_vec++;
    if (count !== 3'd1) begin n_err++; $display("FAIL hold_first_count got %0d want 1", count); end
    n_vec++;
    if (dout !== 3'b101 || dout_vld !== 1'b1) begin
      n_err++; $display("FAIL hold_first_dout got %b/%b want 101/1", dout, dout_vld);
    end
    for (int i = 0; i < 9; i++) step();
    n_vec++;
    if (count !== 3'd1) begin n_err++; $display("FAIL hold_end_count got %0d want 1", count); end
    n_vec++;
    if (dout !== 3'b101) begin n_err++; $display("FAIL hold_end_dout got %b want 101", dout); end
    valid = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_vec++;
    if (count !== 3'd0 || dout !== 3'b000 || dout_vld !== 1'b0) begin
      n_err++; $display("FAIL hold_drain got cnt=%0d dout=%b vld=%b want 0/000/0",
                        count, dout, dout_vld);
    end
  endtask

  task automatic test_overflow();
    logic [2:0] exp_q [4];
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd4};
    do_reset();
    valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      y = 3'(i);
      step();
    end
    valid = 1'b0;
    n_vec++;
    if (count !== 3'd4 || full !== 1'b1) begin
      n_err++; $display("FAIL ovf_fill got cnt=%0d full=%b want 4/1", count, full);
    end
    n_vec++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", ovf); end
`ifdef ENC_EVT_DROP_CNT_EN
    n_vec++;
    if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL ovf_dropcnt got %0d want 1", drop_cnt); end
`endif
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (dout !== exp_q[i]) begin
        n_err++; $display("FAIL ovf_pop%0d got %b want %b", i, dout, exp_q[i]);
      end
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    n_vec++;
    if (count !== 3'd0 || ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_after_drain got cnt=%0d ovf=%b want 0/1", count, ovf);
    end
  endtask

  task automatic test_full_pushpop();
    logic [2:0] exp_q [4];
    exp_q = '{3'd2, 3'd3, 3'd4, 3'd6};
    do_reset();
    valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      y = 3'(i);
      step();
    end
    y     = 3'd6;
    rd_en = 1'b1;
    step();
    valid = 1'b0;
    rd_en = 1'b0;
    n_vec++;
    if (count !== 3'd4 || full !== 1'b1) begin
      n_err++; $display("FAIL fullpp_count got cnt=%0d full=%b want 4/1", count, full);
    end
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL fullpp_ovf got %b want 0", ovf); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (dout !== exp_q[i]) begin
        n_err++; $display("FAIL fullpp_pop%0d got %b want %b", i, dout, exp_q[i]);
      end
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
  endtask

  task automatic test_empty_pushpop();
    do_reset();
    valid = 1'b1;
    y     = 3'd3;
    rd_en = 1'b1;
    step();
    valid = 1'b0;
    rd_en = 1'b0;
    n_vec++;
    if (count !== 3'd1 || dout !== 3'b011 || dout_vld !== 1'b1) begin
      n_err++; $display("FAIL emptypp got cnt=%0d dout=%b vld=%b want 1/011/1",
                        count, dout, dout_vld);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid = 1'b1;
    y = 3'd1; step();
    y = 3'd2; step();
    y = 3'd4; step();
    n_vec++;
    if (count !== 3'd3) begin n_err++; $display("FAIL rstmid_pre got %0d want 3", count); end
    rst = 1'b1;
    y   = 3'd6;
    step();
    n_vec++;
    if (count !== 3'd0 || dout_vld !== 1'b0) begin
      n_err++; $display("FAIL rstmid_cleared got cnt=%0d vld=%b want 0/0", count, dout_vld);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (count !== 3'd1 || dout !== 3'b110) begin
      n_err++; $display("FAIL rstmid_first got cnt=%0d dout=%b want 1/110", count, dout);
    end
    step();
    n_vec++;
    if (count !== 3'd1) begin n_err++; $display("FAIL rstmid_hold got %0d want 1", count); end
    valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [2:0] codes [13];
    codes = '{3'd1, 3'd4, 3'd7, 3'd2, 3'd5, 3'd0, 3'd3, 3'd6, 3'd1, 3'd4, 3'd7, 3'd2, 3'd5};
    do_reset();
    valid = 1'b1;
    y     = codes[0];
    step();
    for (int i = 1; i <= 12; i++) begin
      n_vec++;
      if (dout !== codes[i-1]) begin
        n_err++; $display("FAIL wrap_dout%0d got %b want %b", i, dout, codes[i-1]);
      end
      y     = codes[i];
      rd_en = 1'b1;
      step();
      n_vec++;
      if (count !== 3'd1) begin
        n_err++; $display("FAIL wrap_count%0d got %0d want 1", i, count);
      end
    end
    valid = 1'b0;
    rd_en = 1'b0;
    n_vec++;
    if (dout !== codes[12]) begin n_err++; $display("FAIL wrap_last got %b want %b", dout, codes[12]); end
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL wrap_ovf got %b want 0", ovf); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    valid = 1'b0;
    y     = 3'b000;
    rd_en = 1'b0;
    test_reset();
    test_hold();
    test_overflow();
    test_full_pushpop();
    test_empty_pushpop();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/enc_evt_fifo.md
ENC_EVT_FIFO -- requirements
Module: enc_evt_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, event queue depth; legal values 2, 4, 8, 16.
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, occupancy count width.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock only.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Y  input  3  encoded index from the 8-to-3 encoder.
REQ-006 SHALL have port valid  input  1  encoder valid; Y is meaningful only when 1.
REQ-007 SHALL have port rd_en  input  1  consumer pop request.
REQ-008 SHALL have port dout  output  3  head-of-queue event code.
REQ-009 SHALL have port dout_vld  output  1  queue non-empty; dout is meaningful.
REQ-010 SHALL have port full  output  1  count equals DEPTH.
REQ-011 SHALL have port count  output  CW  current occupancy, 0..DEPTH.
REQ-012 SHALL have port ovf  output  1  sticky flag: at least one event dropped.

Function
REQ-013 SHALL register prev_valid and prev_Y from valid and Y every clock edge.
REQ-014 SHALL detect an event when valid=1 and (prev_valid=0 or Y!=prev_Y); valid=0 is never an event.
REQ-015 SHALL produce exactly one event per new code; a code held steady for N cycles yields one entry.
REQ-016 SHALL push the event code (Y) on the same edge that samples the detecting inputs.
REQ-017 SHALL be first-word-fall-through: dout equals the head entry and dout_vld=1 from the cycle after the push edge (1-cycle latency).
REQ-018 SHALL drive dout=3'b000 whenever dout_vld=0.
REQ-019 SHALL pop the head on an edge where rd_en=1 and dout_vld=1; rd_en with empty queue SHALL be ignored.
REQ-020 SHALL, on push and pop in the same edge with queue non-empty, perform both, leaving count unchanged; this holds when full.
REQ-021 SHALL, on push and pop in the same edge with queue empty, ignore the pop and store the event; no bypass.
REQ-022 SHALL, on push with full=1 and no pop, drop the event, leave contents unchanged and set ovf=1.
REQ-023 SHALL hold ovf at 1 until reset; no other clear.
REQ-024 SHALL use read/write pointers that wrap from DEPTH-1 to 0; order SHALL be preserved across wrap.
REQ-025 SHALL keep count, full and dout_vld consistent every cycle: full=(count==DEPTH), dout_vld=(count!=0).

Reset
REQ-026 SHALL on rst=1 at a clock edge clear pointers, count, ovf, prev_valid, prev_Y; outputs then read dout=000, dout_vld=0, full=0, count=0, ovf=0.
REQ-027 SHALL give reset priority over push and pop; a reset mid-operation discards all queued events.
REQ-028 SHALL treat valid held high across reset release as a new event on the first edge with rst=0.
REQ-029 SHALL not require storage array contents to be reset.

Configuration
REQ-030 SHALL, when macro ENC_EVT_DROP_CNT_EN is defined, add output drop_cnt  8  count of dropped events, incremented on each REQ-022 drop, saturating at 255, cleared by reset.
REQ-031 SHALL, when ENC_EVT_DROP_CNT_EN is undefined, omit drop_cnt and its logic; all other behaviour identical.

Verification
REQ-032 SHALL cover: reset, then valid=1, Y=5 held 10 cycles, rd_en=0 -> count=1, dout=101, dout_vld=1 one cycle after first sample, no further pushes.
REQ-033 SHALL cover: Y sequence 1,2,3,4,5 one per cycle with valid=1, rd_en=0, DEPTH=4 -> count=4, full=1, ovf=1, pops return 001,010,011,100; with macro drop_cnt=1.
REQ-034 SHALL cover: full queue, new event and rd_en=1 same edge -> count stays 4, head advances, new code at tail.
REQ-035 SHALL cover: empty queue, event Y=3 and rd_en=1 same edge -> count=1, dout=011 next cycle.
REQ-036 SHALL cover: 3 events queued, rst=1 one cycle with valid=1, Y=6 held -> after release count=0, then one event 110 pushed on first non-reset edge.
REQ-037 SHALL cover: 12 push/pop pairs interleaved -> pointer wrap with in-order dout, ovf=0.
